vproc_vregunpack: RTL and testbench

VPROC_VREGUNPACK -- requirements
Module: vproc_vregunpack

---
 rtl/vproc_pkg.sv | 22 ++
 rtl/vproc_vregunpack_ext.sv | 46 ++++
 rtl/vproc_vregunpack.sv | 138 +++++++++++++
 tb/tb_vproc_vregunpack.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vproc_pkg
// Description : Shared vector-processor configuration types and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package vproc_pkg;

    typedef enum logic [1:0] {
        VSEW_8       = 2'b00,
        VSEW_16      = 2'b01,
        VSEW_32      = 2'b10,
        VSEW_INVALID = 2'b11
    } cfg_vsew;

    // Only 8- and 16-bit sources have a 2x-wide destination.
    function automatic logic vsew_can_widen(input cfg_vsew vsew);
        return (vsew == VSEW_8) || (vsew == VSEW_16);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vproc_vregunpack_ext.sv
`default_nettype none
// ============================================================================
// Module      : vproc_vregunpack_ext
// Description : Widens a half-beat source slice to a full operand beat (8->16
//               or 16->32 bit elements) and spreads the source byte mask.
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_vregunpack_ext
    import vproc_pkg::*;
#(
    parameter int unsigned OP_W = 32
) (
    input  logic [OP_W/2-1:0]  slice_i,
    input  logic [OP_W/16-1:0] mslice_i,
    input  cfg_vsew            vsew_i,
    input  logic               sigext_i,
    output logic [OP_W-1:0]    operand_o,
    output logic [OP_W/8-1:0]  mask_o
);

    always_comb begin
        operand_o = '0;
        mask_o    = '0;
        case (vsew_i)
            VSEW_8: begin
                for (int i = 0; i < int'(OP_W / 16); i++) begin
                    operand_o[16*i +: 16] = {{8{sigext_i & slice_i[8*i+7]}}, slice_i[8*i +: 8]};
                    mask_o[2*i +: 2]      = {2{mslice_i[i]}};
                end
            end
            VSEW_16: begin
                // A halfword element is governed by the mask bit of its low byte.
                for (int j = 0; j < int'(OP_W / 32); j++) begin
                    operand_o[32*j +: 32] = {{16{sigext_i & slice_i[16*j+15]}}, slice_i[16*j +: 16]};
                    mask_o[4*j +: 4]      = {4{mslice_i[2*j]}};
                end
            end
            default: begin
                operand_o = '0;
                mask_o    = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vproc_vregunpack.sv
`default_nettype none
// ============================================================================
// Module      : vproc_vregunpack
// Description : Splits a captured vector register word into operand beats,
//               optionally widening each source element to twice its width.
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_vregunpack
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned OP_W   = 32
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  cfg_vsew             vsew_i,
    input  logic                widen_i,
    input  logic                sigext_i,
    input  logic [VREG_W-1:0]   vreg_i,
    input  logic [VREG_W/8-1:0] vmsk_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OP_W-1:0]     op_o,
    output logic [OP_W/8-1:0]   opmsk_o,
    output logic                out_last_o
);

    localparam int unsigned c_beats = VREG_W / OP_W;
    localparam int unsigned c_cnt_w = $clog2(2 * c_beats);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [VREG_W-1:0]   r_vreg;
    logic [VREG_W/8-1:0] r_vmsk;
    cfg_vsew             r_vsew;
    logic                r_widen;
    logic                r_sigext;

    logic                w_accept;
    logic                w_take;
    logic                w_cnt_last;
    logic [OP_W-1:0]     w_nw_op;
    logic [OP_W/8-1:0]   w_nw_msk;
    logic [OP_W/2-1:0]   w_w_slice;
    logic [OP_W/16-1:0]  w_w_mslice;
    logic [OP_W-1:0]     w_w_op;
    logic [OP_W/8-1:0]   w_w_msk;

    assign w_cnt_last = r_widen ? (r_cnt == c_cnt_w'(2 * c_beats - 1))
                                : (r_cnt == c_cnt_w'(c_beats - 1));
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_take     = out_valid_o & out_ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_take && w_cnt_last && !w_accept) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready overlaps the final handshake so words stream back-to-back
    always_comb begin
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        in_ready_o  = 1'b0;
        case (r_state)
            ST_IDLE: in_ready_o = 1'b1;
            ST_BUSY: begin
                out_valid_o = 1'b1;
                out_last_o  = w_cnt_last;
                in_ready_o  = w_cnt_last & out_ready_i;
            end
            default: in_ready_o = 1'b0;
        endcase
    end

    // Word capture and beat counter
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_cnt    <= '0;
            r_vreg   <= '0;
            r_vmsk   <= '0;
            r_vsew   <= VSEW_8;
            r_widen  <= 1'b0;
            r_sigext <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_vreg   <= vreg_i;
            r_vmsk   <= vmsk_i;
            r_vsew   <= vsew_i;
            r_widen  <= widen_i & vsew_can_widen(vsew_i);
            r_sigext <= sigext_i;
        end else if (w_take) begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign w_nw_op    = OP_W'(r_vreg >> (r_cnt * OP_W));
    assign w_nw_msk   = (OP_W/8)'(r_vmsk >> (r_cnt * (OP_W / 8)));
    assign w_w_slice  = (OP_W/2)'(r_vreg >> (r_cnt * (OP_W / 2)));
    assign w_w_mslice = (OP_W/16)'(r_vmsk >> (r_cnt * (OP_W / 16)));

    vproc_vregunpack_ext #(
        .OP_W (OP_W)
    ) u_ext (
        .slice_i   (w_w_slice),
        .mslice_i  (w_w_mslice),
        .vsew_i    (r_vsew),
        .sigext_i  (r_sigext),
        .operand_o (w_w_op),
        .mask_o    (w_w_msk)
    );

    assign op_o    = r_widen ? w_w_op  : w_nw_op;
    assign opmsk_o = r_widen ? w_w_msk : w_nw_msk;

endmodule
`default_nettype wire

// File: tb/tb_vproc_vregunpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_vproc_vregunpack
// Description : Directed self-checking bench for vproc_vregunpack (128/32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vproc_vregunpack;
    import vproc_pkg::*;

    localparam int unsigned VREG_W = 128;
    localparam int unsigned OP_W   = 32;

    logic                clk;
    logic                sync_rst;
    logic                in_valid;
    logic                in_ready;
    cfg_vsew             vsew;
    logic                widen;
    logic                sigext;
    logic [VREG_W-1:0]   vreg;
    logic [VREG_W/8-1:0] vmsk;
    logic                out_valid;
    logic                out_ready;
    logic [OP_W-1:0]     op;
    logic [OP_W/8-1:0]   opmsk;
    logic                out_last;

    int passed = 0;
    int total  = 0;
    int n;

    localparam logic [127:0] c_word_a = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] c_word_b = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    vproc_vregunpack #(
        .VREG_W (VREG_W),
        .OP_W   (OP_W)
    ) dut (
        .clk_i       (clk),
        .sync_rst_i  (sync_rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .vsew_i      (vsew),
        .widen_i     (widen),
        .sigext_i    (sigext),
        .vreg_i      (vreg),
        .vmsk_i      (vmsk),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .op_o        (op),
        .opmsk_o     (opmsk),
        .out_last_o  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Consume beats with out_ready high until the word ends; returns beats seen.
    task automatic drain(output int beats);
        beats = 0;
        for (int i = 0; i < 40 && out_valid === 1'b1; i++) begin
            beats++;
            step();
        end
    endtask

    task automatic offer(input logic [127:0] w, input logic [15:0] m,
                         input cfg_vsew s, input logic wd, input logic se);
        in_valid = 1'b1;
        vreg     = w;
        vmsk     = m;
        vsew     = s;
        widen    = wd;
        sigext   = se;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        sync_rst  = 1'b1;
        in_valid  = 1'b0;
        vsew      = VSEW_32;
        widen     = 1'b0;
        sigext    = 1'b0;
        vreg      = '0;
        vmsk      = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        chk("rst_op",    64'(op),        64'd0);
        chk("rst_msk",   64'(opmsk),     64'd0);
        chk("rst_ready", 64'(in_ready),  64'd1);
        sync_rst = 1'b0;
        step();

        // Plain pass-through, four beats
        offer(c_word_a, 16'hFFFF, VSEW_32, 1'b0, 1'b0);
        chk("nw_ready_busy", 64'(in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("nw_valid", 64'(out_valid), 64'd1);
            chk("nw_op",    64'(op),        64'(32'h11111111 * k));
            chk("nw_msk",   64'(opmsk),     64'hF);
            chk("nw_last",  64'(out_last),  64'(k == 3));
            step();
        end
        chk("nw_idle_valid", 64'(out_valid), 64'd0);
        chk("nw_idle_ready", 64'(in_ready),  64'd1);

        // Widen bytes, sign-extended
        offer(128'h807F, 16'h0002, VSEW_8, 1'b1, 1'b1);
        chk("w8s_op",  64'(op),    64'hFF80007F);
        chk("w8s_msk", 64'(opmsk), 64'hC);
        drain(n);
        chk("w8s_beats", 64'(n), 64'd8);

        // Widen bytes, zero-extended
        offer(128'h807F, 16'h0002, VSEW_8, 1'b1, 1'b0);
        chk("w8z_op",   64'(op),       64'h0080007F);
        chk("w8z_msk",  64'(opmsk),    64'hC);
        chk("w8z_last", 64'(out_last), 64'd0);
        drain(n);
        chk("w8z_beats", 64'(n), 64'd8);

        // Widen halfwords, sign-extended; second beat carries halfword 1
        offer(128'h1234_8000, 16'h0001, VSEW_16, 1'b1, 1'b1);
        chk("w16_op",  64'(op),    64'hFFFF8000);
        chk("w16_msk", 64'(opmsk), 64'hF);
        step();
        chk("w16_op1",  64'(op),    64'h00001234);
        chk("w16_msk1", 64'(opmsk), 64'h0);
        drain(n);
        chk("w16_beats", 64'(n), 64'd7);

        // Widen request on 32-bit elements degrades to pass-through
        offer(c_word_a, 16'h00F0, VSEW_32, 1'b1, 1'b1);
        chk("w32_op",  64'(op),    64'h0);
        chk("w32_msk", 64'(opmsk), 64'h0);
        step();
        chk("w32_op1",  64'(op),    64'h11111111);
        chk("w32_msk1", 64'(opmsk), 64'hF);
        drain(n);
        chk("w32_beats", 64'(n), 64'd3);

        // Backpressure during beat 1
        offer(c_word_a, 16'hFFFF, VSEW_32, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_op",    64'(op),        64'h11111111);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_last",  64'(out_last),  64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume_op", 64'(op), 64'h22222222);
        drain(n);
        chk("bp_beats", 64'(n), 64'd2);

        // Back-to-back words across the final handshake
        offer(c_word_a, 16'hFFFF, VSEW_32, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("b2b_last", 64'(out_last), 64'd1);
        in_valid = 1'b1;
        vreg     = c_word_b;
        chk("b2b_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_op",    64'(op),        64'hAAAAAAAA);
        chk("b2b_lastb", 64'(out_last),  64'd0);
        drain(n);
        chk("b2b_beats", 64'(n), 64'd4);

        // Reset in the middle of a word
        offer(c_word_a, 16'hFFFF, VSEW_32, 1'b0, 1'b0);
        step();
        step();
        chk("mr_op_pre", 64'(op), 64'h22222222);
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_op",    64'(op),        64'd0);
        chk("mr_msk",   64'(opmsk),     64'd0);
        chk("mr_ready", 64'(in_ready),  64'd1);
        step();
        chk("mr_stay_idle", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
